// File: rtl/mem_pkg.sv
// Shared encodings for the memory access path: size codes, RAM direction, controller states.
package mem_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned RAM_W  = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // Right-justify and zero-extend the read buffer for the requested size.
    function automatic logic [DATA_W-1:0] fmt_rdata(input size_e size, input logic [DATA_W-1:0] rbuf);
        case (size)
            SIZE_BYTE: return {56'd0, rbuf[7:0]};
            SIZE_HALF: return {48'd0, rbuf[15:0]};
            SIZE_WORD: return {32'd0, rbuf[31:0]};
            default:   return rbuf;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_check.sv
// Size/address alignment check plus access byte count; shared with the fetch unit.
module mem_align_check
    import mem_pkg::*;
(
    input  logic [1:0] size,
    input  logic [2:0] addr_lo,
    output logic       misaligned,
    output logic [3:0] byte_count
);

    always_comb begin
        misaligned = 1'b0;
        byte_count = 4'd1;
        case (size_e'(size))
            SIZE_BYTE: begin
                misaligned = 1'b0;
                byte_count = 4'd1;
            end
            SIZE_HALF: begin
                misaligned = addr_lo[0];
                byte_count = 4'd2;
            end
            SIZE_WORD: begin
                misaligned = |addr_lo[1:0];
                byte_count = 4'd4;
            end
            default: begin
                misaligned = |addr_lo;
                byte_count = 4'd8;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response front-end for the byte-addressable data RAM; splits doublewords into two word beats.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned MFC_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              ram_enable,
    output logic              ram_read_write,
    output logic [1:0]        ram_data_length,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_mfc
);

    localparam int unsigned CNT_W = $clog2(MFC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

    state_e              state;
    logic                wr_q;
    size_e               size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_lo_q;
    logic                split_q;
    logic                beat_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rbuf_q;

    logic                misaligned;
    logic [3:0]          byte_count;
    logic                split;

    mem_align_check u_align (
        .size       (req_size),
        .addr_lo    (req_addr[2:0]),
        .misaligned (misaligned),
        .byte_count (byte_count)
    );

    // Anything wider than one RAM word goes out as two word beats.
    assign split = (byte_count > 4'(RAM_W / 8));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            wr_q            <= 1'b0;
            size_q          <= SIZE_BYTE;
            addr_q          <= '0;
            wdata_lo_q      <= '0;
            split_q         <= 1'b0;
            beat_q          <= 1'b0;
            cnt_q           <= '0;
            rbuf_q          <= '0;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_error       <= 1'b0;
            ram_enable      <= 1'b0;
            ram_read_write  <= 1'b0;
            ram_data_length <= 2'd0;
            ram_address     <= '0;
            ram_wdata       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_write;
                        size_q     <= size_e'(req_size);
                        addr_q     <= req_addr;
                        wdata_lo_q <= req_wdata[31:0];
                        split_q    <= split;
                        beat_q     <= 1'b0;
                        cnt_q      <= '0;
                        rbuf_q     <= '0;
                        req_ready  <= 1'b0;
                        if (misaligned) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state           <= ST_ACCESS;
                            ram_enable      <= 1'b1;
                            ram_read_write  <= req_write ? RAM_WRITE : RAM_READ;
                            ram_data_length <= split ? 2'(SIZE_WORD) : req_size;
                            ram_address     <= req_addr;
                            ram_wdata       <= split ? req_wdata[63:32] : req_wdata[31:0];
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (ram_mfc) begin
                        if (split_q && !beat_q) begin
                            rbuf_q[63:32] <= ram_rdata;
                        end else begin
                            rbuf_q[31:0] <= ram_rdata;
                        end
                        ram_enable <= 1'b0;
                        state      <= ST_RECOVER;
                    end else if (cnt_q == CNT_LAST) begin
                        ram_enable <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_error  <= 1'b1;
                        rsp_rdata  <= '0;
                        state      <= ST_RESP;
                    end
                end
                ST_RECOVER: begin
                    // Wait for the RAM to drop mfc so every beat sees a fresh enable edge.
                    if (!ram_mfc) begin
                        if (split_q && !beat_q) begin
                            beat_q      <= 1'b1;
                            cnt_q       <= '0;
                            ram_enable  <= 1'b1;
                            ram_address <= addr_q + ADDR_W'(4);
                            ram_wdata   <= wdata_lo_q;
                            state       <= ST_ACCESS;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_rdata <= wr_q ? '0 : fmt_rdata(size_q, rbuf_q);
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: big-endian RAM model, vector table, scoreboard and corner-case sequences.
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_rdata;
    logic              rsp_error;
    logic              ram_enable;
    logic              ram_read_write;
    logic [1:0]        ram_data_length;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_mfc;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .MFC_TIMEOUT(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .ram_enable      (ram_enable),
        .ram_read_write  (ram_read_write),
        .ram_data_length (ram_data_length),
        .ram_address     (ram_address),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .ram_mfc         (ram_mfc)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // RAM model: combinational mfc while enabled, optional mfc stretch, or mfc stuck low.
    logic [7:0] mem [512];
    logic       mfc_off = 1'b0;
    int         hold_cfg = 0;
    int         hold_left = 0;
    int         cyc_cnt = 0;
    int         en_rises = 0;
    logic       prev_en = 1'b0;
    logic [8:0] a1, a2, a3;

    typedef struct { logic [8:0] addr; logic [31:0] data; logic [1:0] len; } wlog_t;
    wlog_t wlog[$];

    assign ram_mfc = (ram_enable && !mfc_off) || (hold_left != 0);

    always_comb begin
        a1 = ram_address + 9'd1;
        a2 = ram_address + 9'd2;
        a3 = ram_address + 9'd3;
        case (ram_data_length)
            2'd0:    ram_rdata = {24'd0, mem[ram_address]};
            2'd1:    ram_rdata = {16'd0, mem[ram_address], mem[a1]};
            default: ram_rdata = {mem[ram_address], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        prev_en <= ram_enable;
        if (ram_enable && !prev_en) en_rises <= en_rises + 1;
        if (ram_enable && hold_cfg != 0) hold_left <= hold_cfg;
        else if (hold_left != 0) hold_left <= hold_left - 1;
        if (cyc_cnt == 0) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        end else if (reset_n && ram_enable && ram_mfc && !ram_read_write) begin
            wlog.push_back('{ram_address, ram_wdata, ram_data_length});
            case (ram_data_length)
                2'd0: mem[ram_address] <= ram_wdata[7:0];
                2'd1: begin
                    mem[ram_address] <= ram_wdata[15:8];
                    mem[a1]          <= ram_wdata[7:0];
                end
                default: begin
                    mem[ram_address] <= ram_wdata[31:24];
                    mem[a1]          <= ram_wdata[23:16];
                    mem[a2]          <= ram_wdata[15:8];
                    mem[a3]          <= ram_wdata[7:0];
                end
            endcase
        end
    end

    // Scoreboard: expectations queued at issue, compared at the response handshake.
    typedef struct { logic [63:0] rdata; logic err; int lat; } exp_t;
    exp_t exp_q[$];
    int   start_cyc = 0;
    int   valid_cyc = 0;
    logic prev_rv = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (req_valid && req_ready && reset_n) start_cyc = cyc_cnt;
        if (rsp_valid && !prev_rv) valid_cyc = cyc_cnt;
        prev_rv = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_error", 64'(rsp_error), 64'(e.err));
                chk("rsp_latency", 64'(valid_cyc - start_cyc), 64'(e.lat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] size, input logic [8:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata, input logic err,
                          input int lat, input int rsp_wait);
        logic [63:0] snap;
        for (int k = 0; k < 50 && !req_ready; k++) tick();
        if (!req_ready) begin
            chk("req_ready_wait", 64'd0, 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back('{rdata, err, lat});
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 100 && !rsp_valid; k++) tick();
        if (!rsp_valid) begin
            chk("rsp_valid_wait", 64'd0, 64'd1);
            void'(exp_q.pop_back());
            return;
        end
        chk("ram_enable_at_rsp", 64'(ram_enable), 64'd0);
        snap = rsp_rdata;
        for (int k = 0; k < rsp_wait; k++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_size  = 2'd2;
            req_addr  = 9'h100;
            tick();
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_rdata", rsp_rdata, snap);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    typedef struct {
        logic wr; logic [1:0] size; logic [8:0] addr; logic [63:0] wdata;
        logic [63:0] rdata; logic err; int lat; int rises;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic ok;
        vecs.push_back('{1'b1, 2'd2, 9'h010, 64'hDEADBEEF,           64'h0,                 1'b0, 3, 1});
        vecs.push_back('{1'b0, 2'd2, 9'h010, 64'h0,                  64'hDEADBEEF,          1'b0, 3, 1});
        vecs.push_back('{1'b1, 2'd3, 9'h020, 64'h1122334455667788,   64'h0,                 1'b0, 5, 2});
        vecs.push_back('{1'b0, 2'd3, 9'h020, 64'h0,                  64'h1122334455667788,  1'b0, 5, 2});
        vecs.push_back('{1'b0, 2'd0, 9'h025, 64'h0,                  64'h66,                1'b0, 3, 1});
        vecs.push_back('{1'b0, 2'd1, 9'h022, 64'h0,                  64'h3344,              1'b0, 3, 1});
        vecs.push_back('{1'b0, 2'd1, 9'h010, 64'h0,                  64'hDEAD,              1'b0, 3, 1});
        vecs.push_back('{1'b1, 2'd0, 9'h030, 64'hFFFFFFFFFFFFFFAB,   64'h0,                 1'b0, 3, 1});
        vecs.push_back('{1'b0, 2'd2, 9'h030, 64'h0,                  64'hAB000000,          1'b0, 3, 1});
        vecs.push_back('{1'b0, 2'd1, 9'h003, 64'h0,                  64'h0,                 1'b1, 1, 0});
        vecs.push_back('{1'b1, 2'd2, 9'h006, 64'hCAFEF00D,           64'h0,                 1'b1, 1, 0});
        vecs.push_back('{1'b0, 2'd3, 9'h00C, 64'h0,                  64'h0,                 1'b1, 1, 0});
        vecs.push_back('{1'b1, 2'd3, 9'h1F8, 64'hA1A2A3A4B1B2B3B4,   64'h0,                 1'b0, 5, 2});
        vecs.push_back('{1'b0, 2'd3, 9'h1F8, 64'h0,                  64'hA1A2A3A4B1B2B3B4,  1'b0, 5, 2});
        vecs.push_back('{1'b1, 2'd1, 9'h1FE, 64'h123456789ABCBEEF,   64'h0,                 1'b0, 3, 1});
        vecs.push_back('{1'b0, 2'd2, 9'h1FC, 64'h0,                  64'hB1B2BEEF,          1'b0, 3, 1});
        vecs.push_back('{1'b0, 2'd0, 9'h1FF, 64'h0,                  64'hEF,                1'b0, 3, 1});

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ram_enable", 64'(ram_enable), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            r0 = en_rises;
            do_req(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].err, vecs[i].lat, 0);
            chk($sformatf("v%0d_enable_pulses", i), 64'(en_rises - r0), 64'(vecs[i].rises));
        end

        // Doubleword store appears at the RAM as two separate word writes.
        wlog.delete();
        do_req(1'b1, 2'd3, 9'h040, 64'h0102030405060708, 64'h0, 1'b0, 5, 0);
        chk("dw_write_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 2) begin
            chk("dw_beat0_addr", 64'(wlog[0].addr), 64'h040);
            chk("dw_beat0_data", 64'(wlog[0].data), 64'h01020304);
            chk("dw_beat0_len",  64'(wlog[0].len),  64'd2);
            chk("dw_beat1_addr", 64'(wlog[1].addr), 64'h044);
            chk("dw_beat1_data", 64'(wlog[1].data), 64'h05060708);
        end

        // mfc never arrives: 16 ACCESS cycles, then an error response.
        mfc_off = 1'b1;
        r0 = en_rises;
        do_req(1'b0, 2'd2, 9'h010, 64'h0, 64'h0, 1'b1, 17, 0);
        mfc_off = 1'b0;
        chk("timeout_enable_pulses", 64'(en_rises - r0), 64'd1);
        do_req(1'b0, 2'd2, 9'h010, 64'h0, 64'hDEADBEEF, 1'b0, 3, 0);

        // Response backpressure with a stray request that must be ignored.
        do_req(1'b0, 2'd2, 9'h010, 64'h0, 64'hDEADBEEF, 1'b0, 3, 5);

        // mfc stretched 3 cycles after each beat keeps the controller in RECOVER.
        hold_cfg = 3;
        r0 = en_rises;
        do_req(1'b0, 2'd3, 9'h020, 64'h0, 64'h1122334455667788, 1'b0, 11, 0);
        hold_cfg = 0;
        chk("hold_enable_pulses", 64'(en_rises - r0), 64'd2);
        repeat (4) tick();

        // Reset during the second beat of a doubleword load.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd3;
        req_addr  = 9'h020;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("beat1_enable", 64'(ram_enable), 64'd1);
        chk("beat1_address", 64'(ram_address), 64'h024);
        reset_n = 1'b0;
        tick();
        chk("midrst_ram_enable", 64'(ram_enable), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_ram_outputs", {ram_address, ram_wdata, ram_data_length, ram_read_write}, 64'd0);
        chk("midrst_rsp_data", {rsp_rdata[62:0], rsp_error}, 64'd0);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rsp_valid) ok = 1'b0;
        end
        chk("midrst_no_response", 64'(ok), 64'd1);
        do_req(1'b0, 2'd1, 9'h1FE, 64'h0, 64'hBEEF, 1'b0, 3, 0);

        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Clocked request/response front-end that sits directly upstream of the data-path byte-addressable RAM (512 x 8, big-endian).
- Accepts load/store requests from the control unit and checks alignment.
- Sequences RAM enable, read_write, data_length and address, then waits for mfc.
- Splits doubleword accesses into two word beats and returns formatted read data plus an error flag.

Parameters:
ADDR_W, 9, RAM byte-address width
MFC_TIMEOUT, 16, max ACCESS cycles waiting for ram_mfc before aborting with error (≥2)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request (high only in IDLE)
req_write  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=halfword, 2=word, 3=doubleword
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data, right-justified; doubleword uses all 64
rsp_valid  out  1  response available, held until rsp_ready
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  64  load data, zero-extended; 0 for stores and errors
rsp_error  out  1  misaligned request or mfc timeout
ram_enable  out  1  RAM enable
ram_read_write  out  1  1=read, 0=write (RAM convention)
ram_data_length  out  2  RAM size code, same encoding as req_size (only 0..2 driven)
ram_address  out  ADDR_W  RAM byte address
ram_wdata  out  32  to RAM data_in
ram_rdata  in  32  from RAM data_out
ram_mfc  in  1  memory-function-complete from RAM

Behaviour:
- Reset (reset_n low at posedge) forces state IDLE and zeroes every output except req_ready, which is 1.
- Reset mid-operation aborts immediately: no response is produced and ram_enable drops the next cycle.
- A partially written doubleword is not rolled back.
- States: IDLE, ACCESS, RECOVER, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/size/addr/wdata and clear beat index, timeout counter and read buffer.
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
  - Misaligned -> RESP with rsp_error=1 and no RAM access. Aligned -> ACCESS.
- ACCESS:
  - ram_enable=1 and ram_read_write=~write.
  - ram_data_length = size, except dword, which issues WORD (2).
  - ram_address = addr + 4*beat.
  - ram_wdata: byte/half/word = wdata[31:0]; dword beat0 = wdata[63:32], beat1 = wdata[31:0].
  - Timeout counter increments each cycle.
  - ram_mfc sampled 1 -> capture ram_rdata into buffer slot (beat0 -> [63:32] for dword, else [31:0]), then go to RECOVER.
  - Counter reaching MFC_TIMEOUT without mfc -> RESP with rsp_error=1 and rdata=0.
- RECOVER:
  - ram_enable=0, forcing an enable edge between accesses.
  - Stay while ram_mfc=1.
  - When mfc=0: dword with beat=0 -> beat=1, clear counter, go to ACCESS; else go to RESP.
- RESP:
  - rsp_valid=1 with stable rsp_rdata/rsp_error.
  - Read data masks: byte [7:0], half [15:0], word [31:0], dword {beat0,beat1}; upper bits 0.
  - Advance to IDLE on rsp_ready. No new request is accepted until the cycle after the handshake.
- Minimum latency, 1-cycle mfc: accept at cycle 0, ACCESS at cycle 1, RECOVER at cycle 2, rsp_valid at cycle 3.
  - Dword minimum: rsp_valid at cycle 5.
- Address arithmetic is ADDR_W bits. Aligned requests never wrap (dword max 0x1F8 -> beat1 0x1FC).
- ram_mfc is ignored outside ACCESS/RECOVER.
- req_valid is ignored outside IDLE.

Decomposition:
- Shared package mem_pkg:
  - size codes BYTE/HALFWORD/WORD/DOUBLEWORD (0..3)
  - RAM read/write encodings (READ=1, WRITE=0)
  - state encoding
- One natural sub-module, mem_align_check: combinational size/addr -> misaligned flag plus byte-count; reusable by the fetch unit.

Test Plan:
1. Word store then load: store addr 0x010, wdata 0xDEADBEEF; load word 0x010 -> rsp_rdata 0x00000000DEADBEEF, error 0, rsp_valid at cycle 3 of each request.
2. Doubleword: store 0x020, wdata 0x1122334455667788 -> RAM sees word writes 0x11223344@0x020 and 0x55667788@0x024 with enable low between beats; dword load returns the same value; byte load 0x025 -> 0x66.
3. Misalignment: half @0x003, word @0x006, dword @0x00C -> rsp_error=1, rdata 0, ram_enable never asserted.
4. Timeout: hold ram_mfc=0 -> after 16 ACCESS cycles rsp_valid=1, rsp_error=1, ram_enable=0; next request completes normally.
5. Backpressure/recovery: rsp_ready low 5 cycles -> rsp_valid and rdata stable, req_ready=0; mfc held high 3 cycles after access -> stays in RECOVER, no second beat issued.
6. Reset: assert reset_n=0 during dword beat1 ACCESS -> next cycle all outputs 0, req_ready=1, no rsp_valid; halfword load 0x1FE afterwards succeeds.
